// File: rtl/prefetch_unit_if.sv
// Bundle of the prefetcher's memory, redirect and decode-side signals.
// Decode handshake: an entry transfers on a rising edge where o_valid && i_ready; o_valid never depends on i_ready.
interface prefetch_unit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int INST_BYTES = 4
);
    localparam int INST_W = INST_BYTES * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] i_mem_data;
    logic                  i_mem_ack;
    logic [31:0]           o_mem_addr;
    logic                  o_mem_req;
    logic                  o_mem_write;
    logic                  i_redirect;
    logic [31:0]           i_redirect_pc;
    logic                  o_valid;
    logic                  i_ready;
    logic [INST_W-1:0]     o_inst;
    logic [31:0]           o_inst_pc;

    modport master (
        input  i_mem_data, i_mem_ack, i_redirect, i_redirect_pc, i_ready,
        output o_mem_addr, o_mem_req, o_mem_write, o_valid, o_inst, o_inst_pc
    );

    modport slave (
        output i_mem_data, i_mem_ack, i_redirect, i_redirect_pc, i_ready,
        input  o_mem_addr, o_mem_req, o_mem_write, o_valid, o_inst, o_inst_pc
    );
endinterface

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: assembles INST_BYTES memory beats per instruction into a DEPTH-entry queue.
// Define PREFETCH_LITTLE_ENDIAN_EN to place beat k in byte lane k instead of the default big-endian order.
module prefetch_unit #(
    parameter int          INST_BYTES = 4,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          DATA_WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    prefetch_unit_if.master bus,
    output logic           state_dbg
);
    localparam int INST_W = INST_BYTES * DATA_WIDTH;
    localparam int BW     = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic {FETCH = 1'b0, FULL = 1'b1} state_t;

    state_t            state, state_next;
    logic [31:0]       fetch_pc;
    logic [BW-1:0]     beat_idx;
    logic [BW-1:0]     lane;
    logic [INST_W-1:0] asm_q, asm_merged;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count, count_next;
    logic              mem_req, beat, last_beat, push, pop;

`ifdef PREFETCH_LITTLE_ENDIAN_EN
    assign lane = beat_idx;
`else
    assign lane = BW'(INST_BYTES - 1) - beat_idx;
`endif

    assign last_beat = (beat_idx == BW'(INST_BYTES - 1));
    assign beat      = mem_req && bus.i_mem_ack;
    // Redirect wins over everything: a completing beat or pop in that cycle is dropped.
    assign push      = beat && last_beat && !bus.i_redirect;
    assign pop       = (count != '0) && bus.i_ready && !bus.i_redirect;

    always_comb begin
        asm_merged = asm_q;
        for (int k = 0; k < INST_BYTES; k++) begin
            if (lane == BW'(k)) asm_merged[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_mem_data;
        end
    end

    always_comb begin
        count_next = count;
        state_next = state;
        mem_req    = 1'b0;
        if (bus.i_redirect) count_next = '0;
        else                count_next = count + CNT_W'(push) - CNT_W'(pop);
        state_next = (count_next == CNT_W'(DEPTH)) ? FULL : FETCH;
        if (state == FETCH && !i_rst) mem_req = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            beat_idx <= '0;
            asm_q    <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (bus.i_redirect) begin
                fetch_pc <= bus.i_redirect_pc;
                beat_idx <= '0;
                asm_q    <= '0;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (beat) begin
                    if (last_beat) begin
                        fetch_pc <= fetch_pc + 32'(INST_BYTES);
                        beat_idx <= '0;
                        asm_q    <= '0;
                        tail     <= tail + 1'b1;
                    end else begin
                        beat_idx <= beat_idx + 1'b1;
                        asm_q    <= asm_merged;
                    end
                end
                if (pop) head <= head + 1'b1;
            end
        end
    end

    // Queue storage needs no reset: the head is only exposed while count is non-zero.
    always_ff @(posedge i_clk) begin
        if (push) begin
            inst_mem[tail] <= asm_merged;
            pc_mem[tail]   <= fetch_pc;
        end
    end

    assign bus.o_mem_addr  = fetch_pc + 32'(beat_idx);
    assign bus.o_mem_req   = mem_req;
    assign bus.o_mem_write = 1'b0;
    assign bus.o_valid     = (count != '0);
    assign bus.o_inst      = (count != '0) ? inst_mem[head] : '0;
    assign bus.o_inst_pc   = (count != '0) ? pc_mem[head]   : '0;
    assign state_dbg       = (state == FULL);
endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios plus a randomized scoreboard stream.
module tb_prefetch_unit;
    localparam int          IB    = 4;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic state_dbg;

    prefetch_unit_if #(.DATA_WIDTH(8), .INST_BYTES(IB)) bus ();

    prefetch_unit #(.INST_BYTES(IB), .DEPTH(DEPTH), .RESET_PC(RPC), .DATA_WIDTH(8)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0]  mem [256];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    assign bus.i_mem_data = mem[bus.o_mem_addr[7:0]];

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [31:0] r;
        logic [31:0] a;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a = pc + 32'(k);
`ifdef PREFETCH_LITTLE_ENDIAN_EN
            r[k*8 +: 8] = mem[a[7:0]];
`else
            r[(3-k)*8 +: 8] = mem[a[7:0]];
`endif
        end
        return r;
    endfunction

    task automatic apply_reset(input logic ack);
        @(negedge i_clk);
        i_rst = 1'b1;
        bus.i_ready = 1'b0;
        bus.i_redirect = 1'b0;
        bus.i_mem_ack = ack;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.o_valid); else pass_cnt++;
        total_cnt++; if (bus.o_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", bus.o_inst); else pass_cnt++;
        total_cnt++; if (bus.o_inst_pc !== 32'h0) $display("FAIL reset_inst_pc: got %h want 0", bus.o_inst_pc); else pass_cnt++;
        total_cnt++; if (bus.o_mem_req !== 1'b0) $display("FAIL reset_mem_req: got %0b want 0", bus.o_mem_req); else pass_cnt++;
        total_cnt++; if (bus.o_mem_write !== 1'b0) $display("FAIL reset_mem_write: got %0b want 0", bus.o_mem_write); else pass_cnt++;
        total_cnt++; if (bus.o_mem_addr !== RPC) $display("FAIL reset_mem_addr: got %h want %h", bus.o_mem_addr, RPC); else pass_cnt++;
    endtask

    task automatic test_fill();
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL fill_valid_early: got %0b want 0", bus.o_valid); else pass_cnt++;
        total_cnt++; if (bus.o_mem_req !== 1'b1) $display("FAIL fill_mem_req: got %0b want 1", bus.o_mem_req); else pass_cnt++;
        @(posedge i_clk);
        @(negedge i_clk);
        total_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL fill_valid: got %0b want 1", bus.o_valid); else pass_cnt++;
        total_cnt++; if (bus.o_inst !== exp_inst(0)) $display("FAIL fill_inst: got %h want %h", bus.o_inst, exp_inst(0)); else pass_cnt++;
        total_cnt++; if (bus.o_inst_pc !== 32'h0) $display("FAIL fill_pc: got %h want 0", bus.o_inst_pc); else pass_cnt++;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        total_cnt++; if (bus.o_mem_req !== 1'b0) $display("FAIL full_mem_req: got %0b want 0", bus.o_mem_req); else pass_cnt++;
        total_cnt++; if (bus.o_mem_addr !== 32'h8) $display("FAIL full_mem_addr: got %h want 8", bus.o_mem_addr); else pass_cnt++;
        total_cnt++; if (state_dbg !== 1'b1) $display("FAIL full_state: got %0b want 1", state_dbg); else pass_cnt++;
        total_cnt++; if (bus.o_inst !== exp_inst(0)) $display("FAIL full_head: got %h want %h", bus.o_inst, exp_inst(0)); else pass_cnt++;
    endtask

    task automatic test_drain();
        bus.i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.i_ready = 1'b0;
        total_cnt++; if (bus.o_inst !== exp_inst(4)) $display("FAIL drain_inst: got %h want %h", bus.o_inst, exp_inst(4)); else pass_cnt++;
        total_cnt++; if (bus.o_inst_pc !== 32'h4) $display("FAIL drain_pc: got %h want 4", bus.o_inst_pc); else pass_cnt++;
        total_cnt++; if (bus.o_mem_req !== 1'b1) $display("FAIL drain_mem_req: got %0b want 1", bus.o_mem_req); else pass_cnt++;
        total_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL drain_valid: got %0b want 1", bus.o_valid); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        apply_reset(1'b0);
        for (int c = 1; c <= 8; c++) begin
            bus.i_mem_ack = (c % 2 == 0);
            @(posedge i_clk);
            @(negedge i_clk);
            if (c == 7) begin
                total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL wait_valid_early: got %0b want 0", bus.o_valid); else pass_cnt++;
            end
        end
        bus.i_mem_ack = 1'b1;
        total_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL wait_valid: got %0b want 1", bus.o_valid); else pass_cnt++;
        total_cnt++; if (bus.o_inst !== exp_inst(0)) $display("FAIL wait_inst: got %h want %h", bus.o_inst, exp_inst(0)); else pass_cnt++;
    endtask

    task automatic test_redirect();
        apply_reset(1'b1);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        bus.i_redirect = 1'b1;
        bus.i_redirect_pc = 32'h4;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.i_redirect = 1'b0;
        total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL redir_valid: got %0b want 0", bus.o_valid); else pass_cnt++;
        total_cnt++; if (bus.o_mem_addr !== 32'h4) $display("FAIL redir_addr: got %h want 4", bus.o_mem_addr); else pass_cnt++;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL redir_valid_early: got %0b want 0", bus.o_valid); else pass_cnt++;
        @(posedge i_clk);
        @(negedge i_clk);
        total_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL redir_valid_late: got %0b want 1", bus.o_valid); else pass_cnt++;
        total_cnt++; if (bus.o_inst !== exp_inst(4)) $display("FAIL redir_inst: got %h want %h", bus.o_inst, exp_inst(4)); else pass_cnt++;
        total_cnt++; if (bus.o_inst_pc !== 32'h4) $display("FAIL redir_pc: got %h want 4", bus.o_inst_pc); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b1);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", bus.o_valid); else pass_cnt++;
        total_cnt++; if (bus.o_mem_req !== 1'b0) $display("FAIL rstmid_mem_req: got %0b want 0", bus.o_mem_req); else pass_cnt++;
        total_cnt++; if (bus.o_mem_addr !== RPC) $display("FAIL rstmid_addr: got %h want %h", bus.o_mem_addr, RPC); else pass_cnt++;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL rstmid_valid_early: got %0b want 0", bus.o_valid); else pass_cnt++;
        @(posedge i_clk);
        @(negedge i_clk);
        total_cnt++; if (bus.o_inst !== exp_inst(0)) $display("FAIL rstmid_inst: got %h want %h", bus.o_inst, exp_inst(0)); else pass_cnt++;
        total_cnt++; if (bus.o_inst_pc !== 32'h0) $display("FAIL rstmid_pc: got %h want 0", bus.o_inst_pc); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b1);
        bus.i_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            total_cnt++;
            if (bus.o_valid !== (c % 4 == 0)) $display("FAIL b2b_valid c=%0d: got %0b want %0b", c, bus.o_valid, (c % 4 == 0));
            else pass_cnt++;
            if (c % 4 == 0) begin
                total_cnt++;
                if (bus.o_inst_pc !== 32'((c / 4 - 1) * 4)) $display("FAIL b2b_pc c=%0d: got %h want %h", c, bus.o_inst_pc, 32'((c / 4 - 1) * 4));
                else pass_cnt++;
            end
        end
        bus.i_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] next_pc;
        logic [31:0] want_inst;
        logic [31:0] want_pc;
        int pops;
        int cyc;
        apply_reset(1'b1);
        next_pc = RPC;
        pops = 0;
        cyc = 0;
        exp_q.delete();
        exp_pc_q.delete();
        while (exp_q.size() < 4) begin
            exp_q.push_back(exp_inst(next_pc));
            exp_pc_q.push_back(next_pc);
            next_pc += 4;
        end
        while (pops < 40 && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            bus.i_ready = ($urandom_range(0, 1) == 1);
            bus.i_mem_ack = ($urandom_range(0, 3) != 0);
            bus.i_redirect = ($urandom_range(0, 49) == 0);
            if (bus.i_redirect) begin
                bus.i_redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 200));
                exp_q.delete();
                exp_pc_q.delete();
                next_pc = bus.i_redirect_pc;
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back(exp_inst(next_pc));
                exp_pc_q.push_back(next_pc);
                next_pc += 4;
            end
            #1;
            if (!bus.i_redirect && bus.o_valid && bus.i_ready) begin
                want_inst = exp_q.pop_front();
                want_pc = exp_pc_q.pop_front();
                pops++;
                total_cnt++;
                if (bus.o_inst !== want_inst || bus.o_inst_pc !== want_pc)
                    $display("FAIL stream_pop %0d: got %h@%h want %h@%h", pops, bus.o_inst, bus.o_inst_pc, want_inst, want_pc);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (pops < 40) $display("FAIL stream_timeout: got %0d pops want 40", pops); else pass_cnt++;
        @(negedge i_clk);
        bus.i_redirect = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_mem_ack = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
        bus.i_mem_ack = 1'b1;
        bus.i_redirect = 1'b0;
        bus.i_redirect_pc = 32'h0;
        bus.i_ready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wait_states();
        test_redirect();
        test_reset_mid();
        test_back_to_back();
        test_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
